// File: rtl/ipsxe_floating_point_rne_share_arb_v1_0_pkg.sv
// ipsxe_floating_point_rne_share_arb_v1_0_pkg: shared widths, tag type and requester ids for the z-RNE share arbiter
package ipsxe_floating_point_rne_share_arb_v1_0_pkg;
  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;
  typedef struct packed {
    logic vld;
    logic id;
  } tag_t;
  function automatic int zw_calc(input int man_width, input int rne, input int rne1);
    return ((man_width + 1 + rne + rne1) / 2) + 1 - 15;
  endfunction
endpackage

// File: rtl/ipsxe_floating_point_tag_pipe_v1_0.sv
// ipsxe_floating_point_tag_pipe_v1_0: fixed-depth {vld, id} shift register with synchronous clear
module ipsxe_floating_point_tag_pipe_v1_0
  import ipsxe_floating_point_rne_share_arb_v1_0_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic i_clk,
  input  logic i_rst,
  input  tag_t i_tag,
  output tag_t o_tag,
  output logic o_any_vld
);
  tag_t stg [DEPTH];
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) stg[i] <= '0;
    end else begin
      stg[0] <= i_tag;
      for (int i = 1; i < DEPTH; i++) stg[i] <= stg[i-1];
    end
  end
  assign o_tag = stg[DEPTH-1];
  always_comb begin
    o_any_vld = 1'b0;
    for (int i = 0; i < DEPTH; i++) o_any_vld = o_any_vld | stg[i].vld;
  end
endmodule

// File: rtl/ipsxe_floating_point_rne_share_arb_v1_0.sv
// ipsxe_floating_point_rne_share_arb_v1_0: round-robin sharing of one z-RNE APM between two requesters
module ipsxe_floating_point_rne_share_arb_v1_0
  import ipsxe_floating_point_rne_share_arb_v1_0_pkg::*;
#(
  parameter int MAN_WIDTH   = 52,
  parameter int RNE         = 2,
  parameter int RNE1        = 49,
  parameter int RNE_LATENCY = 2,
  localparam int ZW = zw_calc(MAN_WIDTH, RNE, RNE1)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_req0_valid,
  input  logic [ZW-1:0] i_req0_z,
  output logic          o_req0_ready,
  input  logic          i_req1_valid,
  input  logic [ZW-1:0] i_req1_z,
  output logic          o_req1_ready,
  output logic [ZW-1:0] o_rne_z,
  output logic          o_rne_vld,
  input  logic [ZW-2:0] i_rne_z,
  output logic          o_res0_valid,
  output logic [ZW-2:0] o_res0_z,
  output logic          o_res1_valid,
  output logic [ZW-2:0] o_res1_z,
  output logic          o_busy
);
  logic last_grant, grant0, grant1, tags_busy, hit0, hit1;
  tag_t head, tail;
  // On conflict the requester that did not win last time gets the slot
  assign grant0 = !i_rst && i_req0_valid && (!i_req1_valid || last_grant == REQ1);
  assign grant1 = !i_rst && i_req1_valid && (!i_req0_valid || last_grant == REQ0);
  assign o_req0_ready = grant0;
  assign o_req1_ready = grant1;
  assign head = '{vld: grant0 | grant1, id: grant1 ? REQ1 : REQ0};
  assign hit0 = tail.vld && tail.id == REQ0;
  assign hit1 = tail.vld && tail.id == REQ1;
  ipsxe_floating_point_tag_pipe_v1_0 #(.DEPTH(RNE_LATENCY + 1)) u_tag_pipe (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_tag     (head),
    .o_tag     (tail),
    .o_any_vld (tags_busy)
  );
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      last_grant   <= REQ1;
      o_rne_z      <= '0;
      o_rne_vld    <= 1'b0;
      o_res0_valid <= 1'b0;
      o_res0_z     <= '0;
      o_res1_valid <= 1'b0;
      o_res1_z     <= '0;
    end else begin
      o_rne_vld    <= head.vld;
      o_res0_valid <= hit0;
      o_res1_valid <= hit1;
      if (head.vld) begin
        last_grant <= head.id;
        o_rne_z    <= grant1 ? i_req1_z : i_req0_z;
      end
      if (hit0) o_res0_z <= i_rne_z;
      if (hit1) o_res1_z <= i_rne_z;
    end
  end
  assign o_busy = tags_busy | o_res0_valid | o_res1_valid;
endmodule
